div_hilo_ctrl: RTL and testbench

//   Multi-cycle sequencer and HI/LO holding register for the CPU's DIV/DIVU instructions.
//   - Sits between the EX stage and the combinational 32-bit unsigned divider.
//   - Takes the instruction operands, drives magnitude operands into the divider and holds them stable.
//   - Waits DIV_CYCLES clocks for the long combinational path, then applies sign correction.
//   - Writes quotient to LO and remainder to HI; also services MTHI/MTLO.

---
 rtl/div_hilo_ctrl.sv | 164 ++++++++++++++++
 tb/tb_div_hilo_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl
//   Sequencer and HI/LO holding register for DIV/DIVU.
//   - Converts signed operands to magnitudes for an external unsigned
//     combinational divider.
//   - Holds those operands stable for DIV_CYCLES clocks, then samples the
//     divider and applies sign correction.
//   - Also services MTHI/MTLO writes while no divide is in flight.
module div_hilo_ctrl #(
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sign_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] div_dend,
    output logic [31:0] div_sor,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Counter just wide enough to hold DIV_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [31:0]      dend_q,    dend_d;
    logic [31:0]      sor_q,     sor_d;
    logic [31:0]      raw_a_q,   raw_a_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q,    zero_d;
    logic [31:0]      hi_q,      hi_d;
    logic [31:0]      lo_q,      lo_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    // Sign-corrected divider results, used only when the divide completes.
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;

    // Sign correction of the unsigned divider outputs.
    always_comb begin
        quo_fixed = neg_quo_q ? (~div_q + 32'd1) : div_q;
        rem_fixed = neg_rem_q ? (~div_r + 32'd1) : div_r;
    end

    // Next-state logic: operand capture on start, countdown while waiting,
    // result write-back when the count expires, MTHI/MTLO when idle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dend_d    = dend_q;
        sor_d     = sor_q;
        raw_a_d   = raw_a_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Start wins over MTHI/MTLO in the same cycle.
                    neg_quo_d = sign_op & (op_a[31] ^ op_b[31]);
                    neg_rem_d = sign_op & op_a[31];
                    dend_d    = (sign_op & op_a[31]) ? (~op_a + 32'd1) : op_a;
                    sor_d     = (sign_op & op_b[31]) ? (~op_b + 32'd1) : op_b;
                    raw_a_d   = op_a;
                    zero_d    = (op_b == 32'd0);
                    cnt_d     = CNT_INIT;
                    busy_d    = 1'b1;
                    state_d   = ST_WAIT;
                end else begin
                    if (mthi) begin
                        hi_d = wdata;
                    end
                    if (mtlo) begin
                        lo_d = wdata;
                    end
                end
            end
            ST_WAIT: begin
                // dend/sor are deliberately left untouched here: the divider
                // path is multicycle and relies on them staying stable.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (zero_q) begin
                        // Divider output is meaningless for a zero divisor.
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = raw_a_q;
                    end else begin
                        lo_d = quo_fixed;
                        hi_d = rem_fixed;
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any divide in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dend_q    <= '0;
            sor_q     <= '0;
            raw_a_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dend_q    <= dend_d;
            sor_q     <= sor_d;
            raw_a_q   <= raw_a_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign div_dend = dend_q;
    assign div_sor  = sor_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb_div_hilo_ctrl
//   Directed and randomized checks of div_hilo_ctrl against a cycle-level
//   behavioural model. The divider is modelled as a slow combinational block
//   whose outputs are garbage until its operands have been stable long enough.
module tb_div_hilo_ctrl;

    localparam int D = 8;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        sign_op = 1'b0;
    logic [31:0] op_a    = '0;
    logic [31:0] op_b    = '0;
    logic        mthi    = 1'b0;
    logic        mtlo    = 1'b0;
    logic [31:0] wdata   = '0;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] div_dend;
    logic [31:0] div_sor;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    div_hilo_ctrl #(.DIV_CYCLES(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sign_op  (sign_op),
        .op_a     (op_a),
        .op_b     (op_b),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wdata    (wdata),
        .div_dend (div_dend),
        .div_sor  (div_sor),
        .div_q    (div_q),
        .div_r    (div_r),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    // Slow divider: results are only valid once the operands have been held
    // for the full multicycle window; before that it outputs corrupted data.
    logic [31:0] prev_dend  = '0;
    logic [31:0] prev_sor   = '0;
    int          stable_cnt = 0;

    always @(negedge clk) begin
        if (div_dend !== prev_dend || div_sor !== prev_sor) stable_cnt <= 0;
        else                                                stable_cnt <= stable_cnt + 1;
        prev_dend <= div_dend;
        prev_sor  <= div_sor;
    end

    always_comb begin
        div_q = 32'h5A5A_5A5A;
        div_r = 32'hA5A5_A5A5;
        if (div_sor != 32'd0) begin
            div_q = div_dend / div_sor;
            div_r = div_dend % div_sor;
            if (stable_cnt < D - 1) begin
                div_q = ~div_q;
                div_r = div_r ^ 32'h0000_0F0F;
            end
        end
    end

    // Behavioural model state (values expected in the current cycle).
    logic        m_busy, m_done;
    int          m_left;
    logic [31:0] m_hi, m_lo, m_dend, m_sor, p_hi, p_lo;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of DIV/DIVU including the divide-by-zero rule.
    task automatic ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_left = 0;
        m_hi = '0; m_lo = '0; m_dend = '0; m_sor = '0; p_hi = '0; p_lo = '0;
    endtask

    task automatic compare_all();
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("div_dend", div_dend, m_dend);
        chk("div_sor", div_sor, m_sor);
    endtask

    // One clock cycle: drive inputs, advance the model, check mid-next-cycle.
    task automatic cycle(input logic s, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic mh, input logic ml,
                         input logic [31:0] wd);
        start = s; sign_op = sg; op_a = a; op_b = b; mthi = mh; mtlo = ml; wdata = wd;
        m_done = 0;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_done = 1; m_busy = 0;
            end
        end else if (s) begin
            ref_div(sg, a, b, p_lo, p_hi);
            m_dend = (sg && a[31]) ? -a : a;
            m_sor  = (sg && b[31]) ? -b : b;
            m_busy = 1;
            m_left = D;
        end else begin
            if (mh) m_hi = wd;
            if (ml) m_lo = wd;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom, $urandom, 1'b0, 1'b0, $urandom);
    endtask

    // Directed divide with hand-computed expected result at the done cycle.
    task automatic do_div(input string name, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
        cycle(1'b1, sg, a, b, 1'b0, 1'b0, '0);
        idle(D);
        chk({name, ".lo"}, lo, exp_lo);
        chk({name, ".hi"}, hi, exp_hi);
        chk({name, ".done"}, {31'd0, done}, 32'd1);
        $display("div %s sg=%0b a=%h b=%h -> lo=%h hi=%h", name, sg, a, b, lo, hi);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'($urandom_range(0, 20));
            5:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        compare_all();
        chk("reset.busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        do_div("divu_by0", 1'b0, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        do_div("div_by0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        do_div("divu_max1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);

        // Second start and MTLO while busy are ignored.
        cycle(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'd5, 32'd1, 1'b0, 1'b1, 32'h1111_1111);
        idle(D - 1);
        chk("busy_ign.lo", lo, 32'd14);
        chk("busy_ign.hi", hi, 32'd2);
        chk("busy_ign.done", {31'd0, done}, 32'd1);
        idle(1);
        chk("busy_ign.done_pulse", {31'd0, done}, 32'd0);

        // MTHI alone in IDLE, then MTHI together with start.
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hAAAA_0000);
        chk("mthi.hi", hi, 32'hAAAA_0000);
        cycle(1'b1, 1'b0, 32'd50, 32'd5, 1'b1, 1'b0, 32'h1234_5678);
        chk("mthi_start.hi", hi, 32'hAAAA_0000);
        idle(D);
        chk("mthi_start.lo_done", lo, 32'd10);
        chk("mthi_start.hi_done", hi, 32'd0);

        // MTHI and MTLO in the same cycle.
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'hCAFE_F00D);
        chk("mthilo.hi", hi, 32'hCAFE_F00D);
        chk("mthilo.lo", lo, 32'hCAFE_F00D);

        // Reset in the middle of a divide, then a clean divide.
        cycle(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0, '0);
        idle(3);
        do_reset();
        chk("rst_mid.hi", hi, 32'd0);
        chk("rst_mid.lo", lo, 32'd0);
        idle(D + 2);
        do_div("after_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                $display("txn %0d: reset", i);
            end else begin
                logic        s, sg, mh, ml;
                logic [31:0] a, b, wd;
                s  = ($urandom_range(0, 5) == 0);
                sg = $urandom_range(0, 1);
                a  = rnd_op();
                b  = rnd_op();
                mh = ($urandom_range(0, 3) == 0);
                ml = ($urandom_range(0, 3) == 0);
                wd = $urandom;
                cycle(s, sg, a, b, mh, ml, wd);
                if (m_done)
                    $display("txn %0d: done lo=%h hi=%h", i, lo, hi);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
